// File: rtl/nrzi_unstuff_deser.sv
// NRZI decoder, USB bit unstuffer and LSB-first word packer for the receive path.
// Sits between the DP/DM receiver and the packet/PID/CRC logic.
module nrzi_unstuff_deser #(
  parameter int WIDTH      = 8,
  parameter int STUFF_LEN  = 6,
  parameter bit INIT_LEVEL = 1'b1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_bit,
  input  logic                       in_valid,
  output logic [WIDTH-1:0]           out_word,
  output logic [$clog2(WIDTH+1)-1:0] out_count,
  output logic                       word_valid,
  output logic                       pkt_end,
  output logic                       stuff_err,
  output logic                       busy
);

  localparam int CNT_W  = $clog2(WIDTH + 1);
  localparam int ONES_W = $clog2(STUFF_LEN + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  state_t              state_r, state_next_s;
  logic                prev_level_r, prev_level_next_s;
  logic [ONES_W-1:0]   ones_cnt_r, ones_cnt_next_s;
  logic [CNT_W-1:0]    bit_cnt_r, bit_cnt_next_s;
  logic [WIDTH-1:0]    shift_r, shift_next_s;
  logic [WIDTH-1:0]    shifted_s;
  logic [WIDTH-1:0]    out_word_next_s;
  logic [CNT_W-1:0]    out_count_next_s;
  logic                word_valid_next_s, pkt_end_next_s, stuff_err_next_s;
  logic                dec_bit_s, stuff_full_s, violation_s;

  assign dec_bit_s    = (in_bit == prev_level_r);
  assign stuff_full_s = (ones_cnt_r == ONES_W'(STUFF_LEN));
  assign violation_s  = in_valid && stuff_full_s && dec_bit_s;
  assign shifted_s    = shift_r | (WIDTH'(dec_bit_s) << bit_cnt_r);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; ERROR is left only when the packet ends
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) state_next_s = ST_RECV;
        else          state_next_s = ST_IDLE;
      end
      ST_RECV: begin
        if (!in_valid)        state_next_s = ST_IDLE;
        else if (violation_s) state_next_s = ST_ERROR;
        else                  state_next_s = ST_RECV;
      end
      ST_ERROR: begin
        if (!in_valid) state_next_s = ST_IDLE;
        else           state_next_s = ST_ERROR;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    prev_level_next_s = prev_level_r;
    ones_cnt_next_s   = ones_cnt_r;
    bit_cnt_next_s    = bit_cnt_r;
    shift_next_s      = shift_r;
    out_word_next_s   = out_word;
    out_count_next_s  = out_count;
    word_valid_next_s = 1'b0;
    pkt_end_next_s    = 1'b0;
    stuff_err_next_s  = 1'b0;
    if (!in_valid) begin
      prev_level_next_s = INIT_LEVEL;
      ones_cnt_next_s   = {ONES_W{1'b0}};
      bit_cnt_next_s    = {CNT_W{1'b0}};
      shift_next_s      = {WIDTH{1'b0}};
      if (state_r == ST_RECV) begin
        pkt_end_next_s = 1'b1;
        if (bit_cnt_r != {CNT_W{1'b0}}) begin
          word_valid_next_s = 1'b1;
          out_word_next_s   = shift_r;
          out_count_next_s  = bit_cnt_r;
        end else begin
          word_valid_next_s = 1'b0;
        end
      end else if (state_r == ST_ERROR) begin
        pkt_end_next_s = 1'b1;
      end else begin
        pkt_end_next_s = 1'b0;
      end
    end else if (state_r == ST_ERROR) begin
      stuff_err_next_s = 1'b0;
    end else begin
      prev_level_next_s = in_bit;
      if (stuff_full_s) begin
        ones_cnt_next_s = {ONES_W{1'b0}};
        if (dec_bit_s) begin
          // A 1 where a stuffed 0 was due: drop the partial word
          stuff_err_next_s = 1'b1;
          bit_cnt_next_s   = {CNT_W{1'b0}};
          shift_next_s     = {WIDTH{1'b0}};
        end else begin
          stuff_err_next_s = 1'b0;
        end
      end else begin
        if (dec_bit_s) ones_cnt_next_s = ones_cnt_r + ONES_W'(1);
        else           ones_cnt_next_s = {ONES_W{1'b0}};
        if (bit_cnt_r == CNT_W'(WIDTH - 1)) begin
          word_valid_next_s = 1'b1;
          out_word_next_s   = shifted_s;
          out_count_next_s  = CNT_W'(WIDTH);
          bit_cnt_next_s    = {CNT_W{1'b0}};
          shift_next_s      = {WIDTH{1'b0}};
        end else begin
          bit_cnt_next_s = bit_cnt_r + CNT_W'(1);
          shift_next_s   = shifted_s;
        end
      end
    end
  end

  // Datapath and output registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_level_r <= INIT_LEVEL;
      ones_cnt_r   <= {ONES_W{1'b0}};
      bit_cnt_r    <= {CNT_W{1'b0}};
      shift_r      <= {WIDTH{1'b0}};
      out_word     <= {WIDTH{1'b0}};
      out_count    <= {CNT_W{1'b0}};
      word_valid   <= 1'b0;
      pkt_end      <= 1'b0;
      stuff_err    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      prev_level_r <= prev_level_next_s;
      ones_cnt_r   <= ones_cnt_next_s;
      bit_cnt_r    <= bit_cnt_next_s;
      shift_r      <= shift_next_s;
      out_word     <= out_word_next_s;
      out_count    <= out_count_next_s;
      word_valid   <= word_valid_next_s;
      pkt_end      <= pkt_end_next_s;
      stuff_err    <= stuff_err_next_s;
      busy         <= (state_next_s != ST_IDLE);
    end
  end

endmodule

// File: doc/nrzi_unstuff_deser.md
Name: nrzi_unstuff_deser

Overview:
Parametrised successor to the single-bit receive NRZI decoder. Takes the line-level bit stream from the DP/DM receiver and NRZI-decodes it against a configurable idle level. It then removes USB stuffed bits, flags stuffing violations, and packs the decoded data LSB-first into WIDTH-bit words. It sits between the DP/DM receive block and the packet/PID/CRC receive logic, replacing the bit-serial decoder plus separate unstuffer.

Parameters:
WIDTH, 8, data bits per output word (>=2).
STUFF_LEN, 6, consecutive decoded 1s after which one stuffed 0 is expected and discarded.
INIT_LEVEL, 1, line level assumed before the first bit of every packet (J state).

Ports:
clock  in  1  system clock, one bit per cycle when in_valid=1.
reset  in  1  asynchronous, active-high reset.
in_bit  in  1  line-level bit from DP/DM receiver.
in_valid  in  1  high while the DP/DM receiver is sending packet bits. Falls after the last bit.
out_word  out  WIDTH  packed decoded data, LSB = first received bit.
out_count  out  $clog2(WIDTH+1)  number of valid bits in out_word.
word_valid  out  1  one-cycle pulse qualifying out_word/out_count.
pkt_end  out  1  one-cycle pulse, packet finished.
stuff_err  out  1  one-cycle pulse, bit-stuffing violation.
busy  out  1  high while the state is not IDLE.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: state=IDLE, prev_level=INIT_LEVEL, ones counter=0, bit counter=0, shift register=0. All outputs are 0.
- All outputs are registered.
- A bit is consumed on a posedge with in_valid=1 and state != ERROR. This includes the IDLE cycle in which in_valid first rises.
- Decode: d = (in_bit == prev_level). prev_level <= in_bit on each consumed bit.
- Whenever in_valid=0, prev_level <= INIT_LEVEL.
- Unstuff, when the ones counter < STUFF_LEN:
  - d=1 increments the counter; d=0 clears it.
  - d is shifted into the word at position bit_cnt, and bit_cnt increments.
- Unstuff, when the ones counter == STUFF_LEN:
  - d=0 is the stuffed bit. It is discarded (not counted), and the counter clears.
  - d=1 is a violation. stuff_err pulses the next cycle, state goes to ERROR, and the partial word is discarded.
- Word emit: when bit_cnt reaches WIDTH, the next cycle drives out_word = shift register, out_count = WIDTH, word_valid = 1. bit_cnt restarts at 0.
- Latency is 1 cycle from the last bit sample to word_valid.
- Word emit: out_word/out_count hold their value until the next emit. Bits above out_count are 0.
- State machine:
  - IDLE: on in_valid=1, go to RECV (the bit is consumed).
  - RECV: on in_valid=0, go to IDLE. pkt_end pulses the next cycle. If bit_cnt>0, word_valid pulses in the same cycle with out_count = bit_cnt and the partial data in the low bits. Counters clear.
  - RECV: on a stuff violation, go to ERROR.
  - ERROR: input is ignored and nothing is emitted. On in_valid=0, go to IDLE, pkt_end pulses, no word_valid, counters clear.
- Boundaries:
  - A word completion and an in_valid fall cannot share a cycle. If the fall follows a full word, pkt_end comes without word_valid.
  - A missing stuff bit at packet end (counter==STUFF_LEN when in_valid falls) is legal; no error.
  - A one-cycle in_valid gap between packets is sufficient: prev_level reloads and the new packet starts cleanly.
  - Reset mid-packet drops all partial data with no pulses. If in_valid is high at reset release, a new packet begins with the current bit as its first.

Test Plan:
1. Sync field: in_bit 0,1,0,1,0,1,0,0 with in_valid=1, then in_valid=0 -> word_valid with out_word=8'h80 and out_count=8 the cycle after the 8th bit. The next cycle has pkt_end=1 and word_valid=0.
2. Stuffing: in_bit 1,1,1,1,1,1,0,0,0 (9 line bits), then idle -> one word: out_word=8'hFF, out_count=8, stuff_err never asserted, then pkt_end.
3. Violation: in_bit=1 for 7 cycles -> stuff_err pulses the cycle after the 7th bit and busy stays 1. After in_valid falls, pkt_end pulses, no word_valid is produced, and busy drops.
4. Partial word: in_bit 1,0,0, then in_valid=0 -> word_valid and pkt_end in the same cycle, out_word=8'h05, out_count=3.
5. Reset mid-packet: 4 bits in, pulse reset -> all outputs 0 with no word_valid/pkt_end. Then scenario 1 replayed produces 8'h80.
6. Back-to-back: scenario 1, one idle cycle, then scenario 4 -> 8'h80/8, pkt_end, then 8'h05/3 with pkt_end. Confirms prev_level reload to INIT_LEVEL.
